// File: rtl/uart_txd_fifo.sv
// uart_txd_fifo: UART transmitter fed from a small word FIFO.
// Frame format (data bits, parity, stop bits) and bit period are fixed at elaboration.
// Frames go out back-to-back, LSB first, with no idle gap while the FIFO holds data.
module uart_txd_fifo #(
  parameter int unsigned CLK_DIV    = 5208,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk50M,
  input  logic                        rst_n,
  input  logic                        txd_valid,
  input  logic [DATA_BITS-1:0]        txd_data,
  output logic                        txd_ready,
  output logic [$clog2(FIFO_DEPTH):0] txd_level,
  output logic                        txd_busy,
  output logic                        txd_done,
  output logic                        txd_pin
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST  = 16'(CLK_DIV - 1);
  // txd_done is registered, so it is set one clock ahead of the final stop clock
  localparam logic [15:0]   DONE_AT    = 16'(CLK_DIV - 2);
  localparam logic [2:0]    DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic [DATA_BITS-1:0] head;

  // Transmit engine
  state_t               state;
  logic [15:0]          baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] word;

  logic push;
  logic pop;
  logic level_nz;
  logic bit_end;
  logic frame_end;

  // Parity of the whole data word: even makes the total count of ones even, odd makes it odd
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? (^w) : (~^w);
  endfunction

  assign level_nz  = (level != '0);
  assign txd_ready = (level != LEVEL_FULL);
  assign txd_level = level;
  assign push      = txd_valid & txd_ready;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
  // A word leaves the FIFO whenever the engine starts a frame: from IDLE, or straight out of the last stop clock
  assign pop       = level_nz && ((state == IDLE) || frame_end);
  assign head      = mem[rd_ptr];

  // FIFO write port; the word is captured only at push time
  always_ff @(posedge clk50M) begin
    if (push) begin
      mem[wr_ptr] <= txd_data;
    end
  end

  // FIFO pointers and occupancy; a full FIFO refuses a push even when it pops in the same cycle
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Shift register: loaded with the popped word, shifted once at the end of START and each DATA bit
  always_ff @(posedge clk50M) begin
    if (pop) begin
      shift <= head;
      word  <= head;
    end else if (bit_end && ((state == START) || (state == DATA))) begin
      shift <= {1'b0, shift[DATA_BITS-1:1]};
    end
  end

  // Frame sequencer with registered line, busy and done outputs
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      txd_pin  <= 1'b1;
      txd_busy <= 1'b0;
      txd_done <= 1'b0;
    end else begin
      txd_done <= (state == STOP) && (bit_cnt == STOP_LAST) && (baud_cnt == DONE_AT);

      if (state != IDLE) begin
        baud_cnt <= bit_end ? 16'd0 : (baud_cnt + 16'd1);
      end

      case (state)
        IDLE: begin
          txd_pin <= 1'b1;
          if (level_nz) begin
            state    <= START;
            txd_pin  <= 1'b0;
            txd_busy <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end

        START: begin
          if (bit_end) begin
            state   <= DATA;
            txd_pin <= shift[0];
            bit_cnt <= '0;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state   <= PAR;
                txd_pin <= parity_bit(word);
              end else begin
                state   <= STOP;
                txd_pin <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              txd_pin <= shift[0];
            end
          end
        end

        PAR: begin
          if (bit_end) begin
            state   <= STOP;
            txd_pin <= 1'b1;
            bit_cnt <= '0;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              // Queued data chains straight into the next start bit, keeping busy high
              if (level_nz) begin
                state   <= START;
                txd_pin <= 1'b0;
              end else begin
                state    <= IDLE;
                txd_pin  <= 1'b1;
                txd_busy <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          txd_pin  <= 1'b1;
          txd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_txd_fifo.sv
// tb_uart_txd_fifo: three transmitter variants (8N1, 8E2, 8O1) on one clock and reset,
// each compared cycle by cycle against a frame-schedule reference model.
module tb_uart_txd_fifo;

  localparam int CD    = 16;
  localparam int ND    = 3;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       vld [ND];
  logic [7:0] dat [ND];
  logic       rdy [ND];
  logic [2:0] lvl [ND];
  logic       bsy [ND];
  logic       dne [ND];
  logic       pin [ND];

  int n_chk;
  int n_fail;

  // Reference model: queued words and the per-clock line value still to be sent
  logic [7:0] mq    [ND][$];
  bit         sched [ND][$];
  bit         acc   [ND];

  uart_txd_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .clk50M(clk), .rst_n(rst_n), .txd_valid(vld[0]), .txd_data(dat[0]), .txd_ready(rdy[0]),
    .txd_level(lvl[0]), .txd_busy(bsy[0]), .txd_done(dne[0]), .txd_pin(pin[0]));

  uart_txd_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk50M(clk), .rst_n(rst_n), .txd_valid(vld[1]), .txd_data(dat[1]), .txd_ready(rdy[1]),
    .txd_level(lvl[1]), .txd_busy(bsy[1]), .txd_done(dne[1]), .txd_pin(pin[1]));

  uart_txd_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut2 (
    .clk50M(clk), .rst_n(rst_n), .txd_valid(vld[2]), .txd_data(dat[2]), .txd_ready(rdy[2]),
    .txd_level(lvl[2]), .txd_busy(bsy[2]), .txd_done(dne[2]), .txd_pin(pin[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int par_of(input int i);
    return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
  endfunction

  function automatic int stop_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  // Expand one word into its line waveform, one entry per clock
  task automatic add_frame(input int i, input logic [7:0] w);
    int p;
    int s;
    bit pb;
    p = par_of(i);
    s = stop_of(i);
    for (int c = 0; c < CD; c++) sched[i].push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < CD; c++) sched[i].push_back(w[b]);
    if (p != 0) begin
      pb = (($countones(w) % 2) == 1) ^ (p == 2);
      for (int c = 0; c < CD; c++) sched[i].push_back(pb);
    end
    for (int c = 0; c < s * CD; c++) sched[i].push_back(1'b1);
  endtask

  // Model step per clock edge: finish the clock just sent, start a frame if the line is free, accept a push
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ND; i++) begin
        mq[i].delete();
        sched[i].delete();
        acc[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < ND; i++) begin
        bit take;
        logic [7:0] w;
        take = vld[i] && (mq[i].size() != DEPTH);
        if (sched[i].size() > 0) void'(sched[i].pop_front());
        if ((sched[i].size() == 0) && (mq[i].size() > 0)) begin
          w = mq[i].pop_front();
          add_frame(i, w);
        end
        if (take) mq[i].push_back(dat[i]);
        acc[i] = take;
      end
    end
  end

  // Compare every output of every variant against the model between edges
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < ND; i++) begin
        bit ep;
        int ml;
        ep = (sched[i].size() == 0) ? 1'b1 : sched[i][0];
        ml = mq[i].size();
        chk($sformatf("d%0d_pin", i),   pin[i], ep);
        chk($sformatf("d%0d_level", i), lvl[i], ml);
        chk($sformatf("d%0d_ready", i), rdy[i], (ml != DEPTH));
        chk($sformatf("d%0d_busy", i),  bsy[i], (sched[i].size() != 0));
        chk($sformatf("d%0d_done", i),  dne[i], (sched[i].size() == 1));
      end
    end
  end

  task automatic send(input int i, input logic [7:0] w);
    int t;
    vld[i] = 1'b1;
    dat[i] = w;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!acc[i] && (t < 3000));
    if (!acc[i]) chk($sformatf("d%0d_push_timeout", i), acc[i], 1'b1);
    vld[i] = 1'b0;
    dat[i] = 8'($urandom);
  endtask

  task automatic stream(input int i, input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      send(i, 8'($urandom));
    end
  endtask

  task automatic wait_idle();
    int t;
    bit busy_any;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      busy_any = 1'b0;
      for (int i = 0; i < ND; i++)
        if ((mq[i].size() != 0) || (sched[i].size() != 0)) busy_any = 1'b1;
    end while (busy_any && (t < 8000));
    if (busy_any) chk("idle_timeout", busy_any, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit pat [10];
    int done_c [ND];
    int idle_c;
    int t;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < ND; i++) begin
      vld[i] = 1'b0;
      dat[i] = 8'h00;
    end

    // Reset values while held
    repeat (3) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("rst_pin%0d", i),   pin[i], 1'b1);
      chk($sformatf("rst_ready%0d", i), rdy[i], 1'b1);
      chk($sformatf("rst_level%0d", i), lvl[i], 0);
      chk($sformatf("rst_busy%0d", i),  bsy[i], 1'b0);
      chk($sformatf("rst_done%0d", i),  dne[i], 1'b0);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_pin", pin[0], 1'b1);

    // Single frames: 0xA5 on 8N1, 0x07 on 8E2 and 8O1, all pushed on the same edge
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    dat[0] = 8'hA5;
    dat[1] = 8'h07;
    dat[2] = 8'h07;
    for (int i = 0; i < ND; i++) vld[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      vld[i] = 1'b0;
      chk($sformatf("lat_level%0d", i), lvl[i], 1);
      chk($sformatf("lat_pin_high%0d", i), pin[i], 1'b1);
      done_c[i] = -1;
    end
    dat[0] = 8'hFF;
    dat[1] = 8'h00;
    dat[2] = 8'h00;
    idle_c = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0)
        for (int i = 0; i < ND; i++) chk($sformatf("start_pin%0d", i), pin[i], 1'b0);
      if (((c % CD) == CD / 2) && (c < 160)) chk($sformatf("a5_bit%0d", c / CD), pin[0], pat[c / CD]);
      if (c == 152) begin
        chk("even_parity", pin[1], 1'b1);
        chk("odd_parity", pin[2], 1'b0);
      end
      if (c == 184) chk("two_stop_pin", pin[1], 1'b1);
      for (int i = 0; i < ND; i++)
        if (dne[i] && (done_c[i] < 0)) done_c[i] = c;
      if (!bsy[1] && (idle_c < 0)) idle_c = c;
    end
    chk("done_8n1_clk", done_c[0], 159);
    chk("done_8e2_clk", done_c[1], 191);
    chk("done_8o1_clk", done_c[2], 175);
    chk("len_8e2_clk", idle_c, 192);

    // Random traffic: overfill, back-to-back frames, pointer wrap, input changes after push
    fork
      stream(0, 12, 3);
      stream(1, 10, 40);
      stream(2, 10, 0);
    join
    wait_idle();

    // Push coinciding with the frame-end pop at level 2
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    t = 0;
    while ((sched[0].size() != 1) && (t < 400)) begin
      @(negedge clk);
      t++;
    end
    chk("pre_pushpop_level", lvl[0], 2);
    vld[0] = 1'b1;
    dat[0] = 8'h44;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    chk("pushpop_level", lvl[0], 2);
    wait_idle();

    // Reset in the middle of the data bits of 0x00 with more words queued
    send(0, 8'h00);
    send(0, 8'($urandom));
    send(0, 8'($urandom));
    repeat (56) @(negedge clk);
    chk("pre_rst_pin", pin[0], 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_pin", pin[0], 1'b1);
    chk("abort_level", lvl[0], 0);
    chk("abort_busy", bsy[0], 1'b0);
    chk("abort_ready", rdy[0], 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send(0, 8'h3C);
    wait_idle();
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
